gpio_in_cond: RTL

Per-channel input conditioner that sits directly upstream of the AXI GPIO register/interrupt block. It takes raw switch and button pins, synchronises them, and optionally debounces each one with a selectable time. It outputs clean levels for the status/read registers, plus single-cycle edge events for the interrupt-pending logic. Debounce enable, debounce time and edge selection are driven from the GPIO register block's control registers.

---
 rtl/gpio_in_cond.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - synchronised, optionally debounced GPIO input conditioner with edge events
//
// Purpose: conditions raw switch/button pins for the GPIO register block.
//   Each pin is synchronised, optionally debounced with a selectable time,
//   and presented as a clean level plus a one-cycle edge event.
//
// Ports:
//   ACLK        clock
//   ARESET      synchronous active-high reset
//   din         raw asynchronous pins
//   deb_en      per-channel debounce enable
//   deb_time    debounce time select: 0=100us 1=200us 2=500us 3=1000us
//   rise_en     per-channel event enable for rising level
//   fall_en     per-channel event enable for falling level
//   level       conditioned level
//   evt         one-cycle pulse per qualifying level edge
//
// Optional macro GPIO_IN_GLITCH_CNT_EN adds:
//   glitch_clr  zeroes all glitch counters
//   glitch_cnt  8-bit saturating rejected-bounce counter per channel
module gpio_in_cond #(
    parameter int N_CH         = 13,
    parameter int SYNC_STAGES  = 2,
    parameter int CLK_FREQ_MHZ = 100
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [N_CH-1:0] din,
    input  logic [N_CH-1:0] deb_en,
    input  logic [1:0]      deb_time,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
`ifdef GPIO_IN_GLITCH_CNT_EN
    input  logic              glitch_clr,
    output logic [8*N_CH-1:0] glitch_cnt,
`endif
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] evt
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [WW-1:0] WARM_INIT = WW'(SYNC_STAGES + 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s;
    logic [PW-1:0]   presc_q;
    logic            tick;
    logic [WW-1:0]   warm_q;
    logic            warm;

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] cnting_q, cnting_d;   // per-channel COUNT state
    logic [N_CH-1:0] pend_q, pend_d;       // qualifying edge seen, event goes out next cycle
    logic [N_CH-1:0] evt_q;
    logic [N_CH-1:0] bounce;
    logic [9:0]      cnt_q   [N_CH];
    logic [9:0]      cnt_d   [N_CH];
    logic [9:0]      cnt_inc [N_CH];
    logic [9:0]      thr;

    assign s     = sync_q[SYNC_STAGES-1];
    assign tick  = (presc_q == PRESC_TC);
    assign warm  = (warm_q != '0);
    assign level = level_q;
    assign evt   = evt_q;

    always_comb begin
        case (deb_time)
            2'd0:    thr = 10'd100;
            2'd1:    thr = 10'd200;
            2'd2:    thr = 10'd500;
            default: thr = 10'd1000;
        endcase
    end

    always_comb begin
        level_d  = level_q;
        cnting_d = cnting_q;
        bounce   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_inc[i] = (cnt_q[i] == 10'h3FF) ? cnt_q[i] : cnt_q[i] + 10'd1;
            cnt_d[i]   = cnt_q[i];
            if (warm || !deb_en[i]) begin
                level_d[i]  = s[i];
                cnting_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end else if (!cnting_q[i]) begin
                cnting_d[i] = s[i] ^ level_q[i];
            end else if (s[i] == level_q[i]) begin
                cnting_d[i] = 1'b0;
                cnt_d[i]    = '0;
                bounce[i]   = 1'b1;
            end else if (tick) begin
                // Threshold compares the count including this tick, so level
                // moves on the T-th tick after the input diverged.
                if (cnt_inc[i] >= thr) begin
                    level_d[i]  = s[i];
                    cnting_d[i] = 1'b0;
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_inc[i];
                end
            end
        end
        pend_d = warm ? '0
                      : ((level_d & ~level_q & rise_en) | (~level_d & level_q & fall_en));
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            presc_q  <= '0;
            warm_q   <= WARM_INIT;
            level_q  <= '0;
            cnting_q <= '0;
            pend_q   <= '0;
            evt_q    <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            presc_q  <= tick ? '0 : presc_q + 1'b1;
            if (warm) warm_q <= warm_q - 1'b1;
            level_q  <= level_d;
            cnting_q <= cnting_d;
            pend_q   <= pend_d;
            evt_q    <= warm ? '0 : pend_q;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef GPIO_IN_GLITCH_CNT_EN
    logic [7:0] gcnt_q [N_CH];

    // Clear has priority over a bounce in the same cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET || glitch_clr) begin
            for (int i = 0; i < N_CH; i++) gcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bounce[i] && gcnt_q[i] != 8'hFF) gcnt_q[i] <= gcnt_q[i] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_gcnt
        assign glitch_cnt[8*g +: 8] = gcnt_q[g];
    end
`else
    logic unused_bounce;
    assign unused_bounce = ^bounce;
`endif

endmodule
